// File: rtl/fwd_scoreboard_pkg.sv
// Shared widths and helpers for the forwarding/scoreboard slice.
// Vectors are packed with element 0 in the LSBs: element k lives at [k*W +: W].
package fwd_scoreboard_pkg;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned XLEN_DEF      = 32;
    localparam int unsigned NREG_DEF      = 32;
    localparam int unsigned NSTAGE_DEF    = 2;
    localparam int unsigned NRD_DEF       = 2;
    localparam int unsigned RW_DEF        = idx_w(NREG_DEF);

    localparam int unsigned STALL_RUN_W   = 16;
    localparam int unsigned STALL_TOTAL_W = 32;
    localparam logic [STALL_RUN_W-1:0] STALL_RUN_MAX = '1;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Operand/forwarding/scoreboard bundle between the issue stage and fwd_scoreboard.
interface fwd_scoreboard_if
    import fwd_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned NSTAGE = NSTAGE_DEF,
    parameter int unsigned NRD    = NRD_DEF,
    parameter int unsigned RW     = idx_w(NREG)
);
    logic [NRD*RW-1:0]        i_rd_sel;
    logic [NRD*XLEN-1:0]      i_rd_data;
    logic [NSTAGE-1:0]        i_fwd_valid;
    logic [NSTAGE*RW-1:0]     i_fwd_rd;
    logic [NSTAGE*XLEN-1:0]   i_fwd_data;
    logic [NSTAGE-1:0]        i_fwd_late;
    logic                     i_lo_issue;
    logic [RW-1:0]            i_lo_rd;
    logic                     i_lo_done;
    logic [RW-1:0]            i_lo_done_rd;
    logic                     i_flush;
    logic [NRD*XLEN-1:0]      o_op_data;
    logic                     o_pause;
    logic [NREG-1:0]          o_busy;
    logic [STALL_RUN_W-1:0]   o_stall_run;
    logic [STALL_TOTAL_W-1:0] o_stall_total;
    logic                     o_err;

    modport master (
        output i_rd_sel, i_rd_data, i_fwd_valid, i_fwd_rd, i_fwd_data, i_fwd_late,
               i_lo_issue, i_lo_rd, i_lo_done, i_lo_done_rd, i_flush,
        input  o_op_data, o_pause, o_busy, o_stall_run, o_stall_total, o_err
    );

    modport slave (
        input  i_rd_sel, i_rd_data, i_fwd_valid, i_fwd_rd, i_fwd_data, i_fwd_late,
               i_lo_issue, i_lo_rd, i_lo_done, i_lo_done_rd, i_flush,
        output o_op_data, o_pause, o_busy, o_stall_run, o_stall_total, o_err
    );

endinterface

// File: rtl/fwd_scoreboard_fwd_mux.sv
// Per-read-port bypass select: youngest matching live source wins, x0 never forwards.
module fwd_mux
    import fwd_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned NSTAGE = NSTAGE_DEF,
    parameter int unsigned RW     = idx_w(NREG)
) (
    input  logic [RW-1:0]          sel,
    input  logic [XLEN-1:0]        rd_data,
    input  logic [NSTAGE-1:0]      fwd_valid,
    input  logic [NSTAGE*RW-1:0]   fwd_rd,
    input  logic [NSTAGE*XLEN-1:0] fwd_data,
    input  logic [NSTAGE-1:0]      fwd_late,
    output logic [XLEN-1:0]        op_data_c,
    output logic                   late_hit_c
);

    // Walk oldest to youngest so the lowest-index match overwrites the rest.
    always_comb begin
        op_data_c  = rd_data;
        late_hit_c = 1'b0;
        if (sel != '0) begin
            for (int s = NSTAGE - 1; s >= 0; s--) begin
                if (fwd_valid[s] && (fwd_rd[s*RW +: RW] == sel)) begin
                    op_data_c  = fwd_data[s*XLEN +: XLEN];
                    late_hit_c = fwd_late[s];
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand forwarding, long-latency scoreboard, issue stall and stall counters.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned NSTAGE = NSTAGE_DEF,
    parameter int unsigned NRD    = NRD_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    fwd_scoreboard_if.slave bus
);

    localparam int unsigned RW = idx_w(NREG);

    logic [NREG-1:0]          busy_q;
    logic [NREG-1:0]          busy_d;
    logic [STALL_RUN_W-1:0]   run_q;
    logic [STALL_TOTAL_W-1:0] total_q;
    logic                     err_q;

    logic [NREG-1:0]          done_mask_c;
    logic [NREG-1:0]          busy_eff_c;
    logic [NRD-1:0]           late_hit_c;
    logic [NRD-1:0]           rd_stall_c;
    logic                     waw_c;
    logic                     pause_c;

    // A register completing this cycle no longer blocks anyone.
    assign done_mask_c = bus.i_lo_done ? (NREG'(1) << bus.i_lo_done_rd) : '0;
    assign busy_eff_c  = busy_q & ~done_mask_c;

    for (genvar p = 0; p < NRD; p++) begin : g_port
        fwd_mux #(
            .XLEN   (XLEN),
            .NREG   (NREG),
            .NSTAGE (NSTAGE),
            .RW     (RW)
        ) u_mux (
            .sel        (bus.i_rd_sel[p*RW +: RW]),
            .rd_data    (bus.i_rd_data[p*XLEN +: XLEN]),
            .fwd_valid  (bus.i_fwd_valid),
            .fwd_rd     (bus.i_fwd_rd),
            .fwd_data   (bus.i_fwd_data),
            .fwd_late   (bus.i_fwd_late),
            .op_data_c  (bus.o_op_data[p*XLEN +: XLEN]),
            .late_hit_c (late_hit_c[p])
        );

        assign rd_stall_c[p] = (bus.i_rd_sel[p*RW +: RW] != '0) &&
                               (late_hit_c[p] || busy_eff_c[bus.i_rd_sel[p*RW +: RW]]);
    end

    assign waw_c   = bus.i_lo_issue && (bus.i_lo_rd != '0) && busy_eff_c[bus.i_lo_rd];
    assign pause_c = !bus.i_flush && ((|rd_stall_c) || waw_c);

    // Clear on completion first so a same-cycle issue to that register wins.
    always_comb begin
        busy_d = busy_q & ~done_mask_c;
        if (bus.i_lo_issue && !pause_c && (bus.i_lo_rd != '0)) begin
            busy_d[bus.i_lo_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q  <= '0;
            run_q   <= '0;
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (bus.i_lo_done && !busy_q[bus.i_lo_done_rd]) begin
                err_q <= 1'b1;
            end
            if (pause_c) begin
                total_q <= total_q + STALL_TOTAL_W'(1);
            end
            if (!pause_c || bus.i_flush) begin
                run_q <= '0;
            end else if (run_q != STALL_RUN_MAX) begin
                run_q <= run_q + STALL_RUN_W'(1);
            end
        end
    end

    assign bus.o_pause       = pause_c;
    assign bus.o_busy        = busy_q;
    assign bus.o_stall_run   = run_q;
    assign bus.o_stall_total = total_q;
    assign bus.o_err         = err_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed and randomized checks of fwd_scoreboard against a behavioural model.
module tb_fwd_scoreboard;
    import fwd_scoreboard_pkg::*;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned NSTAGE = 2;
    localparam int unsigned NRD    = 2;
    localparam int unsigned RW     = idx_w(NREG);

    logic i_clk = 1'b0;
    logic i_rst_n;

    always #5 i_clk = ~i_clk;

    fwd_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .NSTAGE(NSTAGE), .NRD(NRD)) bus ();

    fwd_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NSTAGE(NSTAGE), .NRD(NRD)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // Reference state: plain per-register flags and integer counters.
    bit          m_busy [NREG];
    bit          m_err;
    int unsigned m_run;
    int unsigned m_total;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < int'(NREG); r++) m_busy[r] = 1'b0;
        m_err   = 1'b0;
        m_run   = 0;
        m_total = 0;
    endtask

    function automatic logic [NREG-1:0] model_busy_vec();
        logic [NREG-1:0] v;
        for (int r = 0; r < int'(NREG); r++) v[r] = m_busy[r];
        return v;
    endfunction

    function automatic bit blocked(input int unsigned r);
        return m_busy[r] && !(bus.i_lo_done && (32'(bus.i_lo_done_rd) == r));
    endfunction

    // Expected operand for port p; returns whether that port needs a stall.
    function automatic bit exp_port(input int p, output logic [XLEN-1:0] d);
        int unsigned sel;
        bit          late;
        sel  = 32'(bus.i_rd_sel[p*RW +: RW]);
        d    = bus.i_rd_data[p*XLEN +: XLEN];
        late = 1'b0;
        if (sel == 0) return 1'b0;
        for (int s = 0; s < int'(NSTAGE); s++) begin
            if (bus.i_fwd_valid[s] && (32'(bus.i_fwd_rd[s*RW +: RW]) == sel)) begin
                d    = bus.i_fwd_data[s*XLEN +: XLEN];
                late = bus.i_fwd_late[s];
                break;
            end
        end
        return late || blocked(sel);
    endfunction

    task automatic idle();
        bus.i_rd_sel     = '0;
        bus.i_rd_data    = '0;
        bus.i_fwd_valid  = '0;
        bus.i_fwd_rd     = '0;
        bus.i_fwd_data   = '0;
        bus.i_fwd_late   = '0;
        bus.i_lo_issue   = 1'b0;
        bus.i_lo_rd      = '0;
        bus.i_lo_done    = 1'b0;
        bus.i_lo_done_rd = '0;
        bus.i_flush      = 1'b0;
    endtask

    task automatic set_port(input int p, input int unsigned sel, input logic [XLEN-1:0] data);
        bus.i_rd_sel[p*RW +: RW]      = RW'(sel);
        bus.i_rd_data[p*XLEN +: XLEN] = data;
    endtask

    task automatic set_src(input int s, input bit v, input int unsigned rd,
                           input logic [XLEN-1:0] data, input bit late);
        bus.i_fwd_valid[s]             = v;
        bus.i_fwd_rd[s*RW +: RW]       = RW'(rd);
        bus.i_fwd_data[s*XLEN +: XLEN] = data;
        bus.i_fwd_late[s]              = late;
    endtask

    // One clock: check combinational outputs, advance model across the edge, check state.
    task automatic cycle(input string tag);
        logic [XLEN-1:0] d;
        bit              p;
        #1;
        p = 1'b0;
        for (int i = 0; i < int'(NRD); i++) begin
            p |= exp_port(i, d);
            chk({tag, "_op"}, 64'(bus.o_op_data[i*XLEN +: XLEN]), 64'(d));
        end
        if (bus.i_lo_issue && (bus.i_lo_rd != '0) && blocked(32'(bus.i_lo_rd))) p = 1'b1;
        if (bus.i_flush) p = 1'b0;
        chk({tag, "_pause"}, 64'(bus.o_pause), 64'(p));
        @(posedge i_clk);
        if (bus.i_lo_done) begin
            if (!m_busy[bus.i_lo_done_rd]) m_err = 1'b1;
            m_busy[bus.i_lo_done_rd] = 1'b0;
        end
        if (bus.i_lo_issue && !p && (bus.i_lo_rd != '0)) m_busy[bus.i_lo_rd] = 1'b1;
        if (p) begin
            m_total = m_total + 1;
            m_run   = (m_run == 32'hFFFF) ? m_run : m_run + 1;
        end else begin
            m_run = 0;
        end
        #1;
        chk({tag, "_busy"},  64'(bus.o_busy),        64'(model_busy_vec()));
        chk({tag, "_run"},   64'(bus.o_stall_run),   64'(m_run));
        chk({tag, "_total"}, 64'(bus.o_stall_total), 64'(m_total));
        chk({tag, "_err"},   64'(bus.o_err),         64'(m_err));
    endtask

    initial begin
        int unsigned q [$];
        idle();
        model_reset();
        i_rst_n = 1'b0;
        #12;
        chk("rst_busy",  64'(bus.o_busy),        64'(0));
        chk("rst_run",   64'(bus.o_stall_run),   64'(0));
        chk("rst_total", 64'(bus.o_stall_total), 64'(0));
        chk("rst_err",   64'(bus.o_err),         64'(0));
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Test 1: youngest source wins
        set_port(0, 5, 32'h11);
        set_src(0, 1'b1, 5, 32'hAA, 1'b0);
        set_src(1, 1'b1, 5, 32'hBB, 1'b0);
        cycle("t1");
        chk("t1_op_aa", 64'(bus.o_op_data[XLEN-1:0]), 64'(32'hAA));
        chk("t1_nopause", 64'(bus.o_pause), 64'(0));

        // Test 2: x0 never forwards
        idle();
        set_port(0, 0, 32'h0);
        set_src(0, 1'b1, 0, 32'h1234, 1'b0);
        cycle("t2");
        chk("t2_op_zero", 64'(bus.o_op_data[XLEN-1:0]), 64'(0));
        chk("t2_nopause", 64'(bus.o_pause), 64'(0));

        // Test 3: late load hit stalls, counters track, run clears on release
        idle();
        set_src(0, 1'b1, 3, 32'h55, 1'b1);
        set_port(0, 3, 32'h0);
        repeat (3) cycle("t3");
        chk("t3_pause", 64'(bus.o_pause), 64'(1));
        chk("t3_run3", 64'(bus.o_stall_run), 64'(3));
        chk("t3_total3", 64'(bus.o_stall_total), 64'(3));
        idle();
        cycle("t3r");
        chk("t3_run0", 64'(bus.o_stall_run), 64'(0));
        chk("t3_total_hold", 64'(bus.o_stall_total), 64'(3));

        // Test 4: long op blocks reader, completion unblocks same cycle
        idle();
        bus.i_lo_issue = 1'b1;
        bus.i_lo_rd    = RW'(7);
        cycle("t4i");
        chk("t4_busy7", 64'(bus.o_busy[7]), 64'(1));
        idle();
        set_port(0, 7, 32'h7);
        cycle("t4s");
        chk("t4_stall", 64'(bus.o_pause), 64'(1));
        bus.i_lo_done    = 1'b1;
        bus.i_lo_done_rd = RW'(7);
        #1;
        chk("t4_unblock", 64'(bus.o_pause), 64'(0));
        cycle("t4d");
        chk("t4_busy7_clr", 64'(bus.o_busy[7]), 64'(0));

        // Test 5: done+issue same register keeps busy; done on idle register is an error
        idle();
        bus.i_lo_issue = 1'b1;
        bus.i_lo_rd    = RW'(9);
        cycle("t5i");
        bus.i_lo_done    = 1'b1;
        bus.i_lo_done_rd = RW'(9);
        cycle("t5b");
        chk("t5_busy9", 64'(bus.o_busy[9]), 64'(1));
        idle();
        bus.i_lo_done    = 1'b1;
        bus.i_lo_done_rd = RW'(4);
        cycle("t5e");
        chk("t5_err", 64'(bus.o_err), 64'(1));
        idle();
        cycle("t5h");
        chk("t5_err_sticky", 64'(bus.o_err), 64'(1));

        // Test 6: async reset mid-cycle
        bus.i_lo_issue = 1'b1;
        bus.i_lo_rd    = RW'(2);
        cycle("t6i");
        idle();
        set_port(1, 9, 32'h9);
        cycle("t6s");
        chk("t6_pre_run", 64'(bus.o_stall_run != 0), 64'(1));
        #2;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_busy",  64'(bus.o_busy),        64'(0));
        chk("t6_run",   64'(bus.o_stall_run),   64'(0));
        chk("t6_total", 64'(bus.o_stall_total), 64'(0));
        chk("t6_err",   64'(bus.o_err),         64'(0));
        idle();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // Randomized traffic on a small register window to provoke hits
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < int'(NRD); i++) set_port(i, $urandom_range(0, 7), 32'($urandom));
            for (int s = 0; s < int'(NSTAGE); s++)
                set_src(s, 1'($urandom_range(0, 1)), $urandom_range(0, 7), 32'($urandom),
                        $urandom_range(0, 3) == 0);
            bus.i_lo_issue = ($urandom_range(0, 3) == 0);
            bus.i_lo_rd    = RW'($urandom_range(0, 7));
            q.delete();
            for (int r = 1; r < 8; r++) if (m_busy[r]) q.push_back(r);
            bus.i_lo_done    = ($urandom_range(0, 2) == 0);
            if ((q.size() > 0) && ($urandom_range(0, 7) != 0))
                bus.i_lo_done_rd = RW'(q[$urandom_range(0, q.size() - 1)]);
            else
                bus.i_lo_done_rd = RW'($urandom_range(0, 7));
            bus.i_flush = ($urandom_range(0, 7) == 0);
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
